// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_bitsub.sv
// One-bit full subtractor cell: D = A - B - BI, with borrow out BO.
module bitsub (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  assign D  = A ^ B ^ BI;
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock, LSB first,
// with start/done handshake and borrow/overflow/zero flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bin;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_ovf;
  logic               r_zero;

  logic               w_d;
  logic               w_bo;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_nxt;

  bitsub u_bitsub (
    .A  (r_sh_a[0]),
    .B  (r_sh_b[0]),
    .BI (r_bin),
    .D  (w_d),
    .BO (w_bo)
  );

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sh_a <= a;
            r_sh_b <= b;
            r_cnt  <= '0;
            r_bin  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          r_res  <= w_res_nxt;
          r_bin  <= w_bo;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            // On the last bit the operand LSBs are the captured sign bits and w_d is diff's MSB.
            r_diff   <= w_res_nxt;
            r_borrow <= w_bo;
            r_ovf    <= (r_sh_a[0] ^ r_sh_b[0]) & (r_sh_a[0] ^ w_d);
            r_zero   <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, ignored start,
// mid-operation reset, back-to-back issue and randomized operands vs. an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int unsigned n_checks;
  int unsigned n_errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues one operation at the next falling edge; inj>=2 pulses a competing start
  // (a=FF, b=00) in that RUN cycle, which must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int inj);
    logic [W-1:0] e_diff;
    logic         e_borrow;
    logic         e_ovf;
    logic         e_zero;
    int           sd;
    int           lat;
    e_diff   = ta - tb;
    e_borrow = (ta < tb);
    sd       = int'($signed(ta)) - int'($signed(tb));
    e_ovf    = (sd > 127) || (sd < -128);
    e_zero   = (e_diff == '0);

    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    a     = ta;
    b     = tb;
    start = 1'b1;
    lat   = 0;
    for (int c = 1; c <= 4 * W; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check_eq("busy_run", {31'd0, busy}, 32'd1);
      end
      if (inj >= 2 && c == inj) begin
        a     = '1;
        b     = '0;
        start = 1'b1;
      end
      if (inj >= 2 && c == inj + 1) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      check_eq("done_timeout", {31'd0, done}, 32'd1);
    end else begin
      check_eq("latency", lat, W + 1);
      check_eq("busy_done", {31'd0, busy}, 32'd1);
      check_eq("diff", {24'd0, diff}, {24'd0, e_diff});
      check_eq("borrow", {31'd0, borrow}, {31'd0, e_borrow});
      check_eq("ovf", {31'd0, ovf}, {31'd0, e_ovf});
      check_eq("zero", {31'd0, zero}, {31'd0, e_zero});
    end
  endtask

  logic [W-1:0] dir_a [5];
  logic [W-1:0] dir_b [5];
  logic         seen_done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    dir_a    = '{8'h05, 8'h03, 8'h80, 8'h5A, 8'h00};
    dir_b    = '{8'h03, 8'h05, 8'h01, 8'h5A, 8'hFF};

    #1;
    check_eq("rst_busy",   {31'd0, busy},   32'd0);
    check_eq("rst_done",   {31'd0, done},   32'd0);
    check_eq("rst_diff",   {24'd0, diff},   32'd0);
    check_eq("rst_borrow", {31'd0, borrow}, 32'd0);
    check_eq("rst_ovf",    {31'd0, ovf},    32'd0);
    check_eq("rst_zero",   {31'd0, zero},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 0);
    repeat (3) @(negedge clk);
    check_eq("diff_hold", {24'd0, diff}, 32'h02);

    for (int i = 0; i < 5; i++) run_op(dir_a[i], dir_b[i], 0);

    run_op(8'h40, 8'h13, 3);

    // Abort at the fourth RUN cycle; previous diff (0x2D) is nonzero.
    @(negedge clk);
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_diff", {24'd0, diff}, 32'd0);
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_done |= done;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      seen_done |= done;
    end
    check_eq("abort_no_done", {31'd0, seen_done}, 32'd0);

    run_op(8'hC3, 8'h3C, 0);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
